// File: rtl/fetch_stage.sv
// RV32I instruction fetch with IF/ID pipeline register.
// Keeps one imem request in flight, uses a one-entry skid buffer under stall, and flushes on redirect.
module fetch_stage #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc4
);

    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic            valid_d;
    logic [XLEN-1:0] instr_d, id_pc_d, id_pc4_d;
    logic            load;
    logic [XLEN-1:0] load_instr, load_pc;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign imem_addr    = pc_q;

    // Next-state, fetch request and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        imem_req     = 1'b0;
        load         = 1'b0;
        load_instr   = skid_instr_q;
        load_pc      = skid_pc_q;
        valid_d      = if_id_valid;
        instr_d      = if_id_instr;
        id_pc_d      = if_id_pc;
        id_pc4_d     = if_id_pc4;

        case (state_q)
            S_REQ: begin
                imem_req = !redirect_valid && !rst;
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d      = redirect_tgt;
                    discard_d = 1'b1;
                end else if (imem_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else if (!stall) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        load_pc    = pc_q;
                        pc_d       = pc_q + INSTR_BYTES;
                        state_d    = S_REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (!stall) begin
                    load    = 1'b1;
                    pc_d    = pc_q + INSTR_BYTES;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect flushes, stall holds, otherwise load or insert a bubble.
        if (redirect_valid) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                valid_d  = 1'b1;
                instr_d  = load_instr;
                id_pc_d  = load_pc;
                id_pc4_d = load_pc + INSTR_BYTES;
            end else begin
                valid_d = 1'b0;
                instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            discard_q    <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            if_id_valid  <= 1'b0;
            if_id_instr  <= NOP_INSTR;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            discard_q    <= discard_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            if_id_valid  <= valid_d;
            if_id_instr  <= instr_d;
            if_id_pc     <= id_pc_d;
            if_id_pc4    <= id_pc4_d;
        end
    end

endmodule
